// File: rtl/gray_arb_pkg.sv
// Shared types and helpers for the gray_conv_arbiter block.
package gray_arb_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  localparam logic MODE_B2G = 1'b0;
  localparam logic MODE_G2B = 1'b1;

  // Width of a requester index; a single requester still needs one bit.
  function automatic int calc_id_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/gray_conv_core.sv
// Combinational binary<->Gray converter shared by all requesters.
module gray_conv_core
  import gray_arb_pkg::*;
#(
  parameter int SIZE = 10
) (
  input  logic [SIZE-1:0] bin_or_gray,
  input  logic            mode,
  output logic [SIZE-1:0] result
);

  logic [SIZE-1:0] g2b;
  logic [SIZE-1:0] b2g;

  assign b2g = bin_or_gray ^ (bin_or_gray >> 1);

  // Gray->binary: each output bit is the XOR of all Gray bits at or above it.
  always_comb begin
    g2b = '0;
    for (int i = 0; i < SIZE; i++) begin
      g2b[i] = ^(bin_or_gray >> i);
    end
  end

  assign result = (mode == MODE_G2B) ? g2b : b2g;

endmodule

// File: rtl/gray_conv_arbiter.sv
// Arbitrates NUM_REQ requesters onto one Gray converter with a single-entry
// output register. Define GRAY_ARB_FIXED_PRIO_EN for fixed lowest-index
// priority instead of round-robin; ports and latency do not change.
module gray_conv_arbiter
  import gray_arb_pkg::*;
#(
  parameter int SIZE    = 10,
  parameter int NUM_REQ = 4,
  parameter int ID_W    = calc_id_w(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ-1:0]      req_mode,
  input  logic [NUM_REQ*SIZE-1:0] req_data,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [SIZE-1:0]         resp_data,
  output logic [ID_W-1:0]         resp_id,
  output logic                    resp_mode,
  output logic                    busy
);

  state_t            state;
  state_t            state_next;
  logic              any_req;
  logic              grant_fire;
  logic [ID_W-1:0]   grant_id;
  logic [SIZE-1:0]   sel_data_p0;
  logic              sel_mode_p0;
  logic [SIZE-1:0]   conv_data_p0;
  logic [SIZE-1:0]   data_p1;
  logic [ID_W-1:0]   id_p1;
  logic              mode_p1;
  logic              vld_p1;

`ifdef GRAY_ARB_FIXED_PRIO_EN
  // Fixed priority: the lowest-index valid requester wins.
  always_comb begin
    grant_id = '0;
    any_req  = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        grant_id = ID_W'(i);
        any_req  = 1'b1;
      end
    end
  end
`else
  logic [ID_W-1:0] rr_ptr;

  // Round-robin: scan from rr_ptr+1 with wrap; the closest valid requester
  // is written last so it wins.
  always_comb begin
    int idx;
    idx      = 0;
    grant_id = '0;
    any_req  = 1'b0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (req_valid[idx]) begin
        grant_id = ID_W'(idx);
        any_req  = 1'b1;
      end
    end
  end

  // Pointer remembers the last winner; moves only on a grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= ID_W'(NUM_REQ - 1);
    end else if (grant_fire) begin
      rr_ptr <= grant_id;
    end
  end
`endif

  // Grant only while the output register is empty and not in reset.
  assign grant_fire = (state == ST_IDLE) && any_req && !rst;

  // One-hot ready towards the winning requester.
  always_comb begin
    req_ready = '0;
    if (grant_fire) begin
      req_ready[grant_id] = 1'b1;
    end
  end

  // Stage p0: select the winner and convert
  assign sel_data_p0 = req_data[grant_id*SIZE +: SIZE];
  assign sel_mode_p0 = req_mode[grant_id];

  gray_conv_core #(
    .SIZE (SIZE)
  ) u_conv (
    .bin_or_gray (sel_data_p0),
    .mode        (sel_mode_p0),
    .result      (conv_data_p0)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state: fill on grant, empty when downstream accepts.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (grant_fire) state_next = ST_BUSY;
      ST_BUSY: if (resp_ready) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Stage p1: output register, loaded on grant and held until drained
  always_ff @(posedge clk) begin
    if (rst) begin
      data_p1 <= '0;
      id_p1   <= '0;
      mode_p1 <= MODE_B2G;
    end else if (grant_fire) begin
      data_p1 <= conv_data_p0;
      id_p1   <= grant_id;
      mode_p1 <= sel_mode_p0;
    end
  end

  assign vld_p1     = (state == ST_BUSY);
  assign resp_valid = vld_p1;
  assign busy       = vld_p1;
  assign resp_data  = data_p1;
  assign resp_id    = id_p1;
  assign resp_mode  = mode_p1;

endmodule
